// File: rtl/fsk_frame_scheduler_if.sv
// Byte-stream bundle shared by the two requesters, the frame scheduler and the FSK transmitter.
// The master modport is the scheduler side; slave is the requester/transmitter side.
interface fsk_frame_scheduler_if;
    logic [7:0] s0_data;
    logic       s0_valid;
    logic       s0_last;
    logic       s0_ready;
    logic [7:0] s1_data;
    logic       s1_valid;
    logic       s1_last;
    logic       s1_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        input  s0_data, s0_valid, s0_last,
        output s0_ready,
        input  s1_data, s1_valid, s1_last,
        output s1_ready,
        output tx_data, tx_valid,
        input  tx_ready
    );

    modport slave (
        output s0_data, s0_valid, s0_last,
        input  s0_ready,
        output s1_data, s1_valid, s1_last,
        input  s1_ready,
        input  tx_data, tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/fsk_frame_scheduler.sv
// Round-robin frame scheduler in front of fsk_gen: wraps one requester's payload as
// preamble, sync, payload and XOR checksum, then holds off arbitration for an inter-frame gap.
module fsk_frame_scheduler #(
    parameter int         PREAMBLE_LEN = 2,
    parameter logic [7:0] SYNC_BYTE    = 8'hD3,
    parameter int         MAX_LEN      = 64,
    parameter int         GAP_CYCLES   = 1000
) (
    input  logic                         clk,
    input  logic                         rstn,
    fsk_frame_scheduler_if.master        bus,
    output logic [1:0]                   grant_o,
    output logic                         busy_o,
    output logic                         frame_done_o,
    output logic                         err_overlen_o
);

    localparam int              GapW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [3:0]      PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [7:0]      LEN_LAST = 8'(MAX_LEN - 1);
    localparam logic [GapW-1:0] GAP_LOAD = GapW'(GAP_CYCLES);
    localparam logic [GapW-1:0] GAP_ONE  = GapW'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SYNC     = 3'd2,
        PAYLOAD  = 3'd3,
        CKSUM    = 3'd4,
        GAP      = 3'd5
    } state_t;

    state_t          state_q;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic [1:0]      grant_q;
    logic            prio_s1_q;
    logic            frame_done_q;
    logic            err_overlen_q;
    logic [7:0]      cksum_q;
    logic [3:0]      pre_cnt_q;
    logic [7:0]      len_cnt_q;
    logic [GapW-1:0] gap_cnt_q;
    logic            ck_loaded_q;

    logic [7:0] src_data;
    logic       src_valid;
    logic       src_last;
    logic       src_ready;
    logic       src_fire;
    logic       tx_fire;
    logic       pick_s1;
    logic       req_any;

    // Requester ready comes only from registered state so it never loops back through valid.
    assign src_ready = (state_q == PAYLOAD) & ~tx_valid_q;
    assign src_data  = grant_q[1] ? bus.s1_data : bus.s0_data;
    assign src_last  = grant_q[1] ? bus.s1_last : bus.s0_last;
    assign src_valid = (grant_q[1] & bus.s1_valid) | (grant_q[0] & bus.s0_valid);
    assign src_fire  = src_ready & src_valid;
    assign tx_fire   = tx_valid_q & bus.tx_ready;

    assign req_any = bus.s0_valid | bus.s1_valid;
    assign pick_s1 = bus.s1_valid & (~bus.s0_valid | prio_s1_q);

    assign bus.s0_ready  = grant_q[0] & src_ready;
    assign bus.s1_ready  = grant_q[1] & src_ready;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign grant_o       = grant_q;
    assign busy_o        = (state_q != IDLE);
    assign frame_done_o  = frame_done_q;
    assign err_overlen_o = err_overlen_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            grant_q       <= 2'b00;
            prio_s1_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            err_overlen_q <= 1'b0;
            cksum_q       <= 8'h00;
            pre_cnt_q     <= 4'd0;
            len_cnt_q     <= 8'd0;
            gap_cnt_q     <= '0;
            ck_loaded_q   <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            err_overlen_q <= 1'b0;
            if (tx_fire) begin
                tx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if ((gap_cnt_q == '0) && req_any) begin
                        grant_q     <= pick_s1 ? 2'b10 : 2'b01;
                        cksum_q     <= 8'h00;
                        len_cnt_q   <= 8'd0;
                        pre_cnt_q   <= 4'd0;
                        ck_loaded_q <= 1'b0;
                        state_q     <= PREAMBLE;
                    end
                end

                PREAMBLE: begin
                    if (!tx_valid_q) begin
                        tx_data_q  <= 8'h55;
                        tx_valid_q <= 1'b1;
                    end else if (bus.tx_ready) begin
                        if (pre_cnt_q == PRE_LAST) begin
                            pre_cnt_q <= 4'd0;
                            state_q   <= SYNC;
                        end else begin
                            pre_cnt_q <= pre_cnt_q + 4'd1;
                        end
                    end
                end

                SYNC: begin
                    if (!tx_valid_q) begin
                        tx_data_q  <= SYNC_BYTE;
                        tx_valid_q <= 1'b1;
                    end else if (bus.tx_ready) begin
                        state_q <= PAYLOAD;
                    end
                end

                PAYLOAD: begin
                    if (src_fire) begin
                        tx_data_q  <= src_data;
                        tx_valid_q <= 1'b1;
                        cksum_q    <= cksum_q ^ src_data;
                        len_cnt_q  <= len_cnt_q + 8'd1;
                        // A last byte landing exactly on MAX_LEN is a normal end of frame.
                        if (src_last) begin
                            state_q <= CKSUM;
                        end else if (len_cnt_q == LEN_LAST) begin
                            state_q       <= CKSUM;
                            err_overlen_q <= 1'b1;
                        end
                    end
                end

                CKSUM: begin
                    // The final payload byte is still pending on entry; the checksum follows it.
                    if (!tx_valid_q) begin
                        if (!ck_loaded_q) begin
                            tx_data_q   <= cksum_q;
                            tx_valid_q  <= 1'b1;
                            ck_loaded_q <= 1'b1;
                        end
                    end else if (bus.tx_ready && ck_loaded_q) begin
                        frame_done_q <= 1'b1;
                        grant_q      <= 2'b00;
                        prio_s1_q    <= grant_q[0];
                        ck_loaded_q  <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                        end else begin
                            gap_cnt_q <= GAP_LOAD;
                            state_q   <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt_q <= GAP_ONE) begin
                        gap_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_ONE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_frame_scheduler.sv
// Directed bench for fsk_frame_scheduler (PREAMBLE_LEN=2, SYNC=0xD3, MAX_LEN=4, GAP_CYCLES=4).
module tb_fsk_frame_scheduler;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] grant;
    logic       busy;
    logic       frameDone;
    logic       errOverlen;

    int checks = 0;
    int errors = 0;

    logic [8:0] s0Q[$];
    logic [8:0] s1Q[$];
    logic [7:0] logData[$];
    logic [1:0] logGrant[$];
    int         logCycle[$];

    int cycleCnt       = 0;
    int frameDoneCnt   = 0;
    int errCnt         = 0;
    int frameDoneCycle = -1;
    int busyFallCycle  = -1;

    fsk_frame_scheduler_if ifc();

    fsk_frame_scheduler #(
        .PREAMBLE_LEN(2),
        .SYNC_BYTE   (8'hD3),
        .MAX_LEN     (4),
        .GAP_CYCLES  (4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (ifc.master),
        .grant_o      (grant),
        .busy_o       (busy),
        .frame_done_o (frameDone),
        .err_overlen_o(errOverlen)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycleCnt++;
    end

    // Requester models and transfer monitor, all evaluated on the falling edge.
    initial begin : driver
        bit fire0;
        bit fire1;
        bit prevBusy;
        fire0 = 1'b0;
        fire1 = 1'b0;
        prevBusy = 1'b0;
        ifc.s0_valid = 1'b0;
        ifc.s0_data  = 8'h00;
        ifc.s0_last  = 1'b0;
        ifc.s1_valid = 1'b0;
        ifc.s1_data  = 8'h00;
        ifc.s1_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                fire0 = 1'b0;
                fire1 = 1'b0;
            end
            if (fire0 && s0Q.size() > 0) void'(s0Q.pop_front());
            if (fire1 && s1Q.size() > 0) void'(s1Q.pop_front());
            ifc.s0_valid = (s0Q.size() > 0);
            ifc.s0_data  = (s0Q.size() > 0) ? s0Q[0][7:0] : 8'h00;
            ifc.s0_last  = (s0Q.size() > 0) ? s0Q[0][8] : 1'b0;
            ifc.s1_valid = (s1Q.size() > 0);
            ifc.s1_data  = (s1Q.size() > 0) ? s1Q[0][7:0] : 8'h00;
            ifc.s1_last  = (s1Q.size() > 0) ? s1Q[0][8] : 1'b0;
            fire0 = ifc.s0_valid && (ifc.s0_ready === 1'b1) && rstn;
            fire1 = ifc.s1_valid && (ifc.s1_ready === 1'b1) && rstn;
            if ((ifc.tx_valid === 1'b1) && ifc.tx_ready && rstn) begin
                logData.push_back(ifc.tx_data);
                logGrant.push_back(grant);
                logCycle.push_back(cycleCnt + 1);
            end
            if (frameDone === 1'b1) begin
                frameDoneCnt++;
                frameDoneCycle = cycleCnt;
            end
            if (errOverlen === 1'b1) errCnt++;
            if (prevBusy && busy === 1'b0) busyFallCycle = cycleCnt;
            prevBusy = (busy === 1'b1);
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] logAt(int i);
        if (i < logData.size()) return logData[i];
        return 8'hxx;
    endfunction

    function automatic logic [1:0] grantAt(int i);
        if (i < logGrant.size()) return logGrant[i];
        return 2'bxx;
    endfunction

    function automatic int cycleAt(int i);
        if (i < logCycle.size()) return logCycle[i];
        return -1000;
    endfunction

    function automatic bit isIdle();
        return (busy === 1'b0) && (s0Q.size() == 0) && (s1Q.size() == 0) && (ifc.tx_valid === 1'b0);
    endfunction

    task automatic clearLog();
        logData.delete();
        logGrant.delete();
        logCycle.delete();
    endtask

    task automatic waitIdle(int budget, string name);
        int n = 0;
        tick();
        while (!isIdle() && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!isIdle()) begin
            errors++;
            $display("[TB] FAIL %s_timeout: busy=%b after %0d cycles, required idle", name, busy, budget);
        end
        tick();
        tick();
    endtask

    task automatic doReset();
        rstn = 1'b0;
        s0Q.delete();
        s1Q.delete();
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        checks++;
        if (ifc.tx_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_tx_valid: got %b required 0", ifc.tx_valid);
        end
        checks++;
        if (ifc.tx_data !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_tx_data: got %h required 00", ifc.tx_data);
        end
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_grant: got %b required 00", grant);
        end
        checks++;
        if ({busy, frameDone, errOverlen} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags: busy/done/err got %b required 000", {busy, frameDone, errOverlen});
        end
        checks++;
        if ({ifc.s0_ready, ifc.s1_ready} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_ready: got %b required 00", {ifc.s0_ready, ifc.s1_ready});
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        logic [7:0] exp[$];
        int fdStart;
        exp = '{8'h55, 8'h55, 8'hD3, 8'h01, 8'h02, 8'h04, 8'h07};
        clearLog();
        fdStart = frameDoneCnt;
        s0Q.push_back({1'b0, 8'h01});
        s0Q.push_back({1'b0, 8'h02});
        s0Q.push_back({1'b1, 8'h04});
        // Valid is presented in cycle 0, grant shows in cycle 1, first 0x55 in cycle 2.
        tick();
        checks++;
        if ({grant, ifc.tx_valid} !== {2'b01, 1'b0}) begin
            errors++; $display("[TB] FAIL latency_grant: grant/tx_valid got %b required 010", {grant, ifc.tx_valid});
        end
        tick();
        checks++;
        if ({ifc.tx_valid, ifc.tx_data} !== {1'b1, 8'h55}) begin
            errors++; $display("[TB] FAIL latency_preamble: valid/data got %h required 155", {ifc.tx_valid, ifc.tx_data});
        end
        waitIdle(200, "single");
        checks++;
        if (logData.size() != exp.size()) begin
            errors++; $display("[TB] FAIL single_len: got %0d bytes required %0d", logData.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if ({grantAt(i), logAt(i)} !== {2'b01, exp[i]}) begin
                errors++;
                $display("[TB] FAIL single_byte%0d: grant/data got %b/%h required 01/%h", i, grantAt(i), logAt(i), exp[i]);
            end
        end
        checks++;
        if (frameDoneCnt - fdStart != 1) begin
            errors++; $display("[TB] FAIL single_done_count: got %0d required 1", frameDoneCnt - fdStart);
        end
        checks++;
        if (busyFallCycle - cycleAt(6) != 4) begin
            errors++; $display("[TB] FAIL single_gap: busy fell %0d cycles after checksum, required 4", busyFallCycle - cycleAt(6));
        end
    endtask

    task automatic test_round_robin();
        doReset();
        clearLog();
        s0Q.push_back({1'b1, 8'hA0});
        s1Q.push_back({1'b1, 8'hB0});
        waitIdle(300, "rr0");
        checks++;
        if ({logData.size() == 10, grantAt(0), logAt(4), grantAt(5), logAt(9)} !== {1'b1, 2'b01, 8'hA0, 2'b10, 8'hB0}) begin
            errors++; $display("[TB] FAIL rr_round0: n=%0d g0=%b c0=%h g1=%b c1=%h required 10/01/a0/10/b0",
                               logData.size(), grantAt(0), logAt(4), grantAt(5), logAt(9));
        end
        clearLog();
        s0Q.push_back({1'b1, 8'hA1});
        s1Q.push_back({1'b1, 8'hB1});
        waitIdle(300, "rr1");
        checks++;
        if ({logData.size() == 10, grantAt(0), logAt(4), grantAt(5), logAt(9)} !== {1'b1, 2'b01, 8'hA1, 2'b10, 8'hB1}) begin
            errors++; $display("[TB] FAIL rr_round1: n=%0d g0=%b c0=%h g1=%b c1=%h required 10/01/a1/10/b1",
                               logData.size(), grantAt(0), logAt(4), grantAt(5), logAt(9));
        end
        clearLog();
        s0Q.push_back({1'b1, 8'hC0});
        waitIdle(300, "rr2");
        checks++;
        if ({logData.size() == 5, grantAt(0), logAt(4)} !== {1'b1, 2'b01, 8'hC0}) begin
            errors++; $display("[TB] FAIL rr_round2: n=%0d g0=%b c0=%h required 5/01/c0", logData.size(), grantAt(0), logAt(4));
        end
        // The last owner was s0, so s1 must win the next contested arbitration.
        clearLog();
        s0Q.push_back({1'b1, 8'hC1});
        s1Q.push_back({1'b1, 8'hD1});
        waitIdle(300, "rr3");
        checks++;
        if ({logData.size() == 10, grantAt(0), logAt(4), grantAt(5), logAt(9)} !== {1'b1, 2'b10, 8'hD1, 2'b01, 8'hC1}) begin
            errors++; $display("[TB] FAIL rr_round3: n=%0d g0=%b c0=%h g1=%b c1=%h required 10/10/d1/01/c1",
                               logData.size(), grantAt(0), logAt(4), grantAt(5), logAt(9));
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[$];
        int n = 0;
        exp = '{8'h55, 8'h55, 8'hD3, 8'h33, 8'h33};
        clearLog();
        ifc.tx_ready = 1'b1;
        s0Q.push_back({1'b1, 8'h33});
        tick();
        while (!((ifc.tx_valid === 1'b1) && (ifc.tx_data === 8'hD3)) && n < 50) begin
            tick();
            n++;
        end
        ifc.tx_ready = 1'b0;
        checks++;
        if (n >= 50) begin
            errors++; $display("[TB] FAIL bp_reach_sync: tx_data=%h never reached d3", ifc.tx_data);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({ifc.tx_valid, ifc.tx_data, ifc.s0_ready, ifc.s1_ready} !== {1'b1, 8'hD3, 2'b00}) begin
                errors++; $display("[TB] FAIL bp_hold%0d: valid/data/rdy got %b/%h/%b required 1/d3/00",
                                   i, ifc.tx_valid, ifc.tx_data, {ifc.s0_ready, ifc.s1_ready});
            end
        end
        ifc.tx_ready = 1'b1;
        waitIdle(200, "bp");
        checks++;
        if (logData.size() != exp.size()) begin
            errors++; $display("[TB] FAIL bp_len: got %0d bytes required %0d", logData.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (logAt(i) !== exp[i]) begin
                errors++; $display("[TB] FAIL bp_byte%0d: got %h required %h", i, logAt(i), exp[i]);
            end
        end
    endtask

    task automatic test_overlen();
        logic [7:0] exp[$];
        int errStart;
        int n = 0;
        exp = '{8'h55, 8'h55, 8'hD3, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00,
                8'h55, 8'h55, 8'hD3, 8'h14, 8'h15, 8'h16, 8'h17};
        clearLog();
        errStart = errCnt;
        for (int b = 8'h10; b <= 8'h15; b++) s1Q.push_back({1'b0, 8'(b)});
        while (logData.size() < 13 && n < 300) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++;
        if ({busy, grant} !== {1'b1, 2'b10}) begin
            errors++; $display("[TB] FAIL ovl_stalled: busy/grant got %b required 110", {busy, grant});
        end
        checks++;
        if (errCnt - errStart != 1) begin
            errors++; $display("[TB] FAIL ovl_err_pulse: got %0d pulses required 1", errCnt - errStart);
        end
        s1Q.push_back({1'b1, 8'h16});
        waitIdle(200, "ovl");
        checks++;
        if (logData.size() != exp.size()) begin
            errors++; $display("[TB] FAIL ovl_len: got %0d bytes required %0d", logData.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if ({grantAt(i), logAt(i)} !== {2'b10, exp[i]}) begin
                errors++; $display("[TB] FAIL ovl_byte%0d: grant/data got %b/%h required 10/%h", i, grantAt(i), logAt(i), exp[i]);
            end
        end
        checks++;
        if (errCnt - errStart != 1) begin
            errors++; $display("[TB] FAIL ovl_err_total: got %0d pulses required 1", errCnt - errStart);
        end
        // Last arriving exactly on the MAX_LEN byte ends the frame cleanly.
        clearLog();
        s0Q.push_back({1'b0, 8'h01});
        s0Q.push_back({1'b0, 8'h02});
        s0Q.push_back({1'b0, 8'h03});
        s0Q.push_back({1'b1, 8'h04});
        waitIdle(200, "ovl_exact");
        checks++;
        if ({logData.size() == 8, logAt(6), logAt(7)} !== {1'b1, 8'h04, 8'h04}) begin
            errors++; $display("[TB] FAIL exact_max: n=%0d last=%h ck=%h required 8/04/04", logData.size(), logAt(6), logAt(7));
        end
        checks++;
        if (errCnt - errStart != 1) begin
            errors++; $display("[TB] FAIL exact_max_err: got %0d pulses required 1", errCnt - errStart);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        clearLog();
        s0Q.push_back({1'b0, 8'h11});
        s0Q.push_back({1'b0, 8'h22});
        s0Q.push_back({1'b1, 8'h33});
        while (logData.size() < 4 && n < 100) begin
            tick();
            n++;
        end
        rstn = 1'b0;
        s0Q.delete();
        tick();
        checks++;
        if ({ifc.tx_valid, ifc.tx_data, grant, busy} !== {1'b0, 8'h00, 2'b00, 1'b0}) begin
            errors++; $display("[TB] FAIL midreset_state: valid/data/grant/busy got %b/%h/%b/%b required 0/00/00/0",
                               ifc.tx_valid, ifc.tx_data, grant, busy);
        end
        rstn = 1'b1;
        tick();
        clearLog();
        s1Q.push_back({1'b1, 8'hAA});
        waitIdle(200, "midreset");
        checks++;
        if ({logData.size() == 5, logAt(3), logAt(4), grantAt(4)} !== {1'b1, 8'hAA, 8'hAA, 2'b10}) begin
            errors++; $display("[TB] FAIL midreset_frame: n=%0d data=%h ck=%h grant=%b required 5/aa/aa/10",
                               logData.size(), logAt(3), logAt(4), grantAt(4));
        end
    endtask

    task automatic test_toggle_ready();
        logic [7:0] exp[$];
        int fdStart;
        int n = 0;
        exp = '{8'h55, 8'h55, 8'hD3, 8'hFF, 8'hFF};
        clearLog();
        fdStart = frameDoneCnt;
        s0Q.push_back({1'b1, 8'hFF});
        tick();
        while (!isIdle() && n < 200) begin
            ifc.tx_ready = ~ifc.tx_ready;
            tick();
            n++;
        end
        ifc.tx_ready = 1'b1;
        tick();
        checks++;
        if (logData.size() != exp.size()) begin
            errors++; $display("[TB] FAIL toggle_len: got %0d transfers required %0d", logData.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (logAt(i) !== exp[i]) begin
                errors++; $display("[TB] FAIL toggle_byte%0d: got %h required %h", i, logAt(i), exp[i]);
            end
        end
        checks++;
        if ((frameDoneCnt - fdStart != 1) || (frameDoneCycle != cycleAt(4))) begin
            errors++; $display("[TB] FAIL toggle_done: pulses=%0d at cycle %0d, required 1 at cycle %0d",
                               frameDoneCnt - fdStart, frameDoneCycle, cycleAt(4));
        end
    endtask

    initial begin
        ifc.tx_ready = 1'b1;
        rstn = 1'b0;
        $display("[TB] fsk_frame_scheduler directed tests start");
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_overlen();
        test_reset_mid_frame();
        test_toggle_ready();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsk_frame_scheduler.md
Name: fsk_frame_scheduler

Overview:
Frame-level controller placed in front of the FSK byte transmitter (fsk_gen). It arbitrates round-robin between two byte-stream requesters and grants one requester for a whole frame. It wraps that requester's payload as preamble, sync byte, payload and XOR checksum, then enforces an inter-frame gap. It drives the transmitter's byte valid/ready interface, so fsk_gen only ever sees complete, well-formed frames.

Parameters:
PREAMBLE_LEN, 2, number of preamble bytes (0x55) per frame; legal range 1..15.
SYNC_BYTE, 8'hD3, sync byte sent after the preamble.
MAX_LEN, 64, maximum payload bytes per frame; legal range 1..255.
GAP_CYCLES, 1000, idle clk cycles after a frame before the next arbitration; 0 means no gap.

Ports:
clk  in  1  clock
rstn  in  1  synchronous, active-low reset
s0_data  in  8  requester 0 payload byte
s0_valid  in  1  requester 0 byte valid
s0_last  in  1  requester 0 final payload byte of the frame
s0_ready  out  1  requester 0 byte accepted when s0_valid is also high
s1_data, s1_valid, s1_last, s1_ready  same as above, requester 1
tx_data  out  8  byte to the FSK transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter ready; a transfer occurs when tx_valid and tx_ready are both high
grant  out  2  one-hot owner of the current frame; 00 when idle
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse when the checksum byte is accepted
err_overlen  out  1  one-cycle pulse when a frame is truncated at MAX_LEN

Behaviour:
- Reset (rstn=0 at posedge), regardless of current state: state=IDLE; tx_valid=0; tx_data=0; grant=00; frame_done=0; err_overlen=0; checksum=0; all counters=0; round-robin pointer set so s0 has priority. Reset mid-frame abandons the frame; partial bytes are not resumed.
- Output register: tx_data and tx_valid are registered.
  - A byte is loaded only when tx_valid=0.
  - On a transfer, tx_valid clears the next cycle. There is always at least one cycle with tx_valid low between bytes.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
- sN_ready = grant[N] & (state==PAYLOAD) & ~tx_valid. It depends on registered signals only. The non-granted requester always sees ready=0.
- States:
  - IDLE: skipped while the gap counter is nonzero.
    - One requester valid: grant it.
    - Both valid: grant the one not granted last time. After reset s0 wins.
    - Grant is registered. Next state is PREAMBLE; checksum and payload count are cleared.
  - PREAMBLE: loads 0x55 PREAMBLE_LEN times, one per transfer. After the last 0x55 is accepted, go to SYNC.
  - SYNC: loads SYNC_BYTE. On acceptance, go to PAYLOAD.
  - PAYLOAD: on a source handshake:
    - tx_data = byte; tx_valid = 1.
    - checksum ^= byte; payload count += 1.
    - If last=1, or count reaches MAX_LEN, go to CKSUM.
    - If MAX_LEN is reached with last=0, pulse err_overlen. The requester's remaining bytes start a new frame after the gap.
    - A requester holding valid low stalls the frame indefinitely; there is no timeout.
  - CKSUM: waits for the last payload byte to be accepted, then loads the checksum.
    - On acceptance: pulse frame_done, clear grant, set the pointer to the other requester, load the gap counter with GAP_CYCLES, go to GAP.
    - If GAP_CYCLES=0, go directly to IDLE.
  - GAP: the gap counter decrements each cycle. At 1, go to IDLE. busy=1 throughout GAP.
- Checksum: 8-bit XOR of payload bytes only, initial value 0x00. Preamble and sync bytes are excluded.
- Simultaneous events:
  - A requester's valid arriving during GAP is held off until IDLE.
  - A last byte and MAX_LEN reached together is treated as last only; no err_overlen.
- Latency: from IDLE with tx_ready held at 1, the first 0x55 appears with tx_valid=1 two cycles after the valid request is sampled.

Test Plan:
1. Single frame, s0 sends {0x01,0x02,0x04} with last on 0x04, tx_ready=1, GAP_CYCLES=4 -> tx sequence 55,55,D3,01,02,04,07; grant=01 for the whole frame; one frame_done pulse; busy falls exactly 4 cycles after the checksum transfer.
2. After reset, s0 and s1 both valid with 1-byte frames -> s0 frame first, then s1; both requesting again -> s0, then s1 (strict alternation).
3. Backpressure: hold tx_ready=0 for 10 cycles while tx_data=0xD3 -> tx_data stays 0xD3 and tx_valid stays 1; s0_ready stays 0; the sequence resumes correctly.
4. MAX_LEN=4: s1 sends 6 bytes 0x10..0x15 with no last -> payload 10,11,12,13 then checksum 0x00; err_overlen pulses once; 0x14 and 0x15 form the next frame after the gap.
5. Reset asserted mid-payload -> next cycle tx_valid=0, grant=00, busy=0; the next frame from s1 with {0xAA} gives checksum 0xAA, confirming no stale accumulation.
6. s0 sends a single byte 0xFF with last while tx_ready toggles every cycle -> bytes 55,55,D3,FF,FF are each transferred exactly once, and frame_done is aligned to the checksum transfer.
